att_feeder: RTL and testbench

ATT_FEEDER -- requirements
Module: att_feeder

---
 rtl/att_feeder.sv | 178 +++++++++++++++++
 tb/tb_att_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/att_feeder.sv
// att_feeder: streams a run of packed {bias, att} words from an operand buffer
// into the attention core, pads with zeros until the core signals completion,
// and reports done/err. State is exposed on o_dbg_state for checkers.
//
// Handshake: start is a one-cycle request, accepted only in IDLE. The sequence
// is finished by a one-cycle done pulse, with err valid in that same cycle.
// Buffer reads are fire-and-forget: read data is valid exactly one cycle after
// each mem_rd_en cycle, and there is no back-pressure.

package definition;
    localparam int att_width = 16;
endpackage

module att_feeder #(
    parameter int ATT_W   = definition::att_width,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [2*ATT_W-1:0] mem_rd_data,
    output logic               en,
    output logic [ATT_W-1:0]   i_att,
    output logic [ATT_W-1:0]   att_bias,
    input  logic               end_flag,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2:0]         o_dbg_state
);

    localparam int DRAIN_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_fin_err;
    logic                w_active;
    logic                w_capture;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [DRAIN_W-1:0]  r_drain;
    logic                r_v1;      // mem_rd_data holds a requested word this cycle
    logic                r_en;
    logic [ATT_W-1:0]    r_att;
    logic [ATT_W-1:0]    r_bias;
    logic                r_err;

    // Next-state decode; w_fin_err marks a transition into FIN that is an error.
    always_comb begin
        w_next    = r_state;
        w_fin_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? S_FETCH : S_FIN;
                end
            end
            S_FETCH: begin
                if (end_flag) begin
                    w_next    = S_FIN;
                    w_fin_err = 1'b1;
                end else if (r_cnt == r_len - LEN_W'(1)) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                // Words are still in flight to the core, so an end here is early.
                if (end_flag) begin
                    w_next    = S_FIN;
                    w_fin_err = 1'b1;
                end else if (!r_v1) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (end_flag) begin
                    w_next = S_FIN;
                end else if (r_drain == DRAIN_W'(TIMEOUT - 1)) begin
                    w_next    = S_FIN;
                    w_fin_err = 1'b1;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Data is only taken while the sequence continues; returns after a cancel
    // or a reset fall on the floor.
    always_comb begin
        w_active  = (w_next == S_FETCH) || (w_next == S_STREAM) || (w_next == S_DRAIN);
        w_capture = r_v1 && ((w_next == S_FETCH) || (w_next == S_STREAM));
    end

    // State register plus error flag that accompanies done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_fin_err;
        end
    end

    // Read address and word counter: captured on accept, stepped each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_IDLE && start && len != '0) begin
            r_addr <= base_addr;
            r_len  <= len;
            r_cnt  <= '0;
        end else if (r_state == S_FETCH) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + LEN_W'(1);
        end
    end

    // Drain counter: counts DRAIN cycles, saturates at TIMEOUT, idle at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain <= '0;
        end else if (r_state == S_DRAIN) begin
            if (r_drain != DRAIN_W'(TIMEOUT)) begin
                r_drain <= r_drain + DRAIN_W'(1);
            end
        end else begin
            r_drain <= '0;
        end
    end

    // Operand pipeline: register returned words, then hold en through drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_en   <= 1'b0;
            r_att  <= '0;
            r_bias <= '0;
        end else begin
            r_v1   <= mem_rd_en;
            r_en   <= w_active && (r_en || r_v1);
            r_att  <= w_capture ? mem_rd_data[ATT_W-1:0]       : '0;
            r_bias <= w_capture ? mem_rd_data[2*ATT_W-1:ATT_W] : '0;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        mem_rd_en   = (r_state == S_FETCH);
        mem_addr    = (r_state == S_FETCH) ? r_addr : '0;
        busy        = (r_state == S_FETCH) || (r_state == S_STREAM) || (r_state == S_DRAIN);
        done        = (r_state == S_FIN);
        err         = r_err;
        en          = r_en;
        i_att       = r_att;
        att_bias    = r_bias;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_att_feeder.sv
// Directed bench for att_feeder: a per-cycle vector table for the nominal run,
// followed by hand-written sequences for wrap, timeout, early end, reset, len=0.

module tb_att_feeder;

    localparam int ATT_W   = 16;
    localparam int ADDR_W  = 8;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 20;

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic [LEN_W-1:0]   len;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [2*ATT_W-1:0] mem_rd_data;
    logic               en;
    logic [ATT_W-1:0]   i_att;
    logic [ATT_W-1:0]   att_bias;
    logic               end_flag;
    logic               busy;
    logic               done;
    logic               err;
    logic [2:0]         dbg_state;

    logic [2*ATT_W-1:0] mem [256];

    int n_vec;
    int n_fail;
    int n_rd;

    att_feeder #(
        .ATT_W   (ATT_W),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .en          (en),
        .i_att       (i_att),
        .att_bias    (att_bias),
        .end_flag    (end_flag),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: one-cycle read latency, returns data every cycle
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
    end

    typedef struct {
        logic        start;
        logic [7:0]  base;
        logic [7:0]  len;
        logic        end_flag;
        logic        rd_en;
        logic [7:0]  addr;
        logic        en;
        logic [15:0] att;
        logic [15:0] bias;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic s, input logic [7:0] b, input logic [7:0] l,
                                input logic ef, input logic rd, input logic [7:0] a,
                                input logic e, input logic [15:0] at, input logic [15:0] bi,
                                input logic bz, input logic d, input logic er);
        vec_t v;
        v.start = s;  v.base = b;  v.len = l;  v.end_flag = ef;
        v.rd_en = rd; v.addr = a;  v.en = e;   v.att = at;  v.bias = bi;
        v.busy = bz;  v.done = d;  v.err = er;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_cnt();
        if (mem_rd_en) n_rd++;
        step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_rd, input logic [7:0] e_addr,
                             input logic e_en, input logic [15:0] e_att, input logic [15:0] e_bias,
                             input logic e_busy, input logic e_done, input logic e_err);
        check($sformatf("%s.rd_en", tag), 32'(mem_rd_en), 32'(e_rd));
        check($sformatf("%s.addr", tag),  32'(mem_addr),  32'(e_addr));
        check($sformatf("%s.en", tag),    32'(en),        32'(e_en));
        check($sformatf("%s.att", tag),   32'(i_att),     32'(e_att));
        check($sformatf("%s.bias", tag),  32'(att_bias),  32'(e_bias));
        check($sformatf("%s.busy", tag),  32'(busy),      32'(e_busy));
        check($sformatf("%s.done", tag),  32'(done),      32'(e_done));
        check($sformatf("%s.err", tag),   32'(err),       32'(e_err));
    endtask

    initial begin
        int early_done;
        logic [7:0] a;

        n_vec = 0;
        n_fail = 0;
        n_rd = 0;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        end_flag = 1'b0;

        for (int i = 0; i < 256; i++) begin
            mem[i] = {16'(i + 16'h100), 16'(i)};
        end
        mem[0]     = 32'hDEAD_BEEF;
        mem[8'h10] = {16'd4, 16'd1};
        mem[8'h11] = {16'd5, 16'd2};
        mem[8'h12] = {16'd6, 16'd3};
        mem[8'h13] = {16'd7, 16'd4};

        // Nominal run: inputs applied in a cycle, outputs expected in the next
        tbl[0]  = mk(1, 8'h10, 8'd4, 0,  1, 8'h10, 0, 16'd0, 16'd0, 1, 0, 0);
        tbl[1]  = mk(0, 8'h00, 8'd0, 0,  1, 8'h11, 0, 16'd0, 16'd0, 1, 0, 0);
        tbl[2]  = mk(0, 8'h00, 8'd0, 0,  1, 8'h12, 1, 16'd1, 16'd4, 1, 0, 0);
        tbl[3]  = mk(0, 8'h00, 8'd0, 0,  1, 8'h13, 1, 16'd2, 16'd5, 1, 0, 0);
        tbl[4]  = mk(1, 8'h40, 8'd2, 0,  0, 8'h00, 1, 16'd3, 16'd6, 1, 0, 0);
        tbl[5]  = mk(0, 8'h00, 8'd0, 0,  0, 8'h00, 1, 16'd4, 16'd7, 1, 0, 0);
        for (int i = 6; i < 12; i++) begin
            tbl[i] = mk(0, 8'h00, 8'd0, 0,  0, 8'h00, 1, 16'd0, 16'd0, 1, 0, 0);
        end
        tbl[12] = mk(0, 8'h00, 8'd0, 1,  0, 8'h00, 0, 16'd0, 16'd0, 0, 1, 0);
        tbl[13] = mk(1, 8'h30, 8'd3, 0,  0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);
        tbl[14] = mk(0, 8'h00, 8'd0, 0,  0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);

        // Reset state
        repeat (3) step();
        check_out("reset", 0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);
        check("reset.state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        step();

        // Nominal table
        for (int i = 0; i < 15; i++) begin
            start     = tbl[i].start;
            base_addr = tbl[i].base;
            len       = tbl[i].len;
            end_flag  = tbl[i].end_flag;
            step();
            check_out($sformatf("nom[%0d]", i), tbl[i].rd_en, tbl[i].addr, tbl[i].en,
                      tbl[i].att, tbl[i].bias, tbl[i].busy, tbl[i].done, tbl[i].err);
        end

        // Address wrap
        start = 1'b1; base_addr = 8'hFE; len = 8'd4;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = 8'hFE + 8'(k);
            check($sformatf("wrap.rd_en%0d", k), 32'(mem_rd_en), 32'd1);
            check($sformatf("wrap.addr%0d", k),  32'(mem_addr),  32'(a));
            if (k == 2) check("wrap.att0", 32'(i_att), 32'h00FE);
            if (k == 3) check("wrap.att1", 32'(i_att), 32'h00FF);
            step();
        end
        check_out("wrap.w2", 0, 8'h00, 1, 16'hBEEF, 16'hDEAD, 1, 0, 0);
        step();
        check_out("wrap.w3", 0, 8'h00, 1, 16'h0001, 16'h0101, 1, 0, 0);
        step();
        check_out("wrap.drain", 0, 8'h00, 1, 16'd0, 16'd0, 1, 0, 0);
        end_flag = 1'b1;
        step();
        end_flag = 1'b0;
        check_out("wrap.fin", 0, 8'h00, 0, 16'd0, 16'd0, 0, 1, 0);
        step();

        // Timeout: drain entered 5 cycles after start, done TIMEOUT cycles later
        start = 1'b1; base_addr = 8'h30; len = 8'd2;
        step();
        start = 1'b0;
        repeat (4) step();
        check_out("tmo.drain", 0, 8'h00, 1, 16'd0, 16'd0, 1, 0, 0);
        early_done = 0;
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            step();
            if (done) early_done++;
        end
        check("tmo.early_done", 32'(early_done), 32'd0);
        check("tmo.en_last", 32'(en), 32'd1);
        step();
        check_out("tmo.fin", 0, 8'h00, 0, 16'd0, 16'd0, 0, 1, 1);
        step();
        check_out("tmo.idle", 0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);

        // Early end_flag during the 3rd streamed word, with a start while busy
        n_rd = 0;
        start = 1'b1; base_addr = 8'h20; len = 8'd8;
        step();
        start = 1'b0;
        step_cnt();
        start = 1'b1; base_addr = 8'h80; len = 8'd1;
        step_cnt();
        start = 1'b0; base_addr = 8'h00; len = 8'd0;
        check("early.addr2", 32'(mem_addr), 32'h22);
        step_cnt();
        step_cnt();
        check_out("early.w2", 1, 8'h24, 1, 16'h0022, 16'h0122, 1, 0, 0);
        end_flag = 1'b1;
        step_cnt();
        end_flag = 1'b0;
        check_out("early.fin", 0, 8'h00, 0, 16'd0, 16'd0, 0, 1, 1);
        step_cnt();
        check_out("early.idle", 0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);
        check("early.reads", 32'(n_rd), 32'd5);

        // Mid-run reset in STREAM, then a len=1 run
        start = 1'b1; base_addr = 8'h10; len = 8'd4;
        step();
        start = 1'b0;
        repeat (4) step();
        check("rst.pre_att", 32'(i_att), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("rst.after", 0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);
        check("rst.state", 32'(dbg_state), 32'd0);
        step();
        check_out("rst.after2", 0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);
        start = 1'b1; base_addr = 8'h12; len = 8'd1;
        step();
        start = 1'b0;
        check_out("len1.rd", 1, 8'h12, 0, 16'd0, 16'd0, 1, 0, 0);
        step();
        check_out("len1.wait", 0, 8'h00, 0, 16'd0, 16'd0, 1, 0, 0);
        step();
        check_out("len1.word", 0, 8'h00, 1, 16'd3, 16'd6, 1, 0, 0);
        step();
        check_out("len1.drain", 0, 8'h00, 1, 16'd0, 16'd0, 1, 0, 0);
        end_flag = 1'b1;
        step();
        end_flag = 1'b0;
        check_out("len1.fin", 0, 8'h00, 0, 16'd0, 16'd0, 0, 1, 0);
        step();

        // len=0: immediate done, no reads, no en
        start = 1'b1; base_addr = 8'h50; len = 8'd0;
        step();
        start = 1'b0;
        check_out("len0.fin", 0, 8'h00, 0, 16'd0, 16'd0, 0, 1, 0);
        step();
        check_out("len0.idle", 0, 8'h00, 0, 16'd0, 16'd0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
